// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for a 5-stage pipeline. It sits beside the ID-stage
// control decoder and does four jobs:
//   - detects load-use hazards between the load in EX and the instruction in ID
//   - squashes wrong-path fetches on jumps and on taken branches
//   - sequences syscalls: drain older instructions, request the handler,
//     wait for the acknowledge, then resume
//   - counts stall cycles in a saturating statistics counter
// The stall, flush and bubble outputs are combinational from state and inputs.
//
// Ports
//   clk, reset       clock (rising edge); synchronous active-high reset
//   id_rs, id_rt     source register fields of the instruction in ID
//   id_uses_rt       the ID instruction really reads rt
//   id_jump, id_sys  decoder flags for the ID instruction
//   ex_memRead       the instruction in EX is a load
//   ex_rt            destination register of that load
//   ex_br_taken      the branch in EX resolved taken
//   sys_ack          the syscall handler is done
//   pc_stall         hold the PC
//   ifid_stall       hold the IF/ID register
//   ifid_flush       clear IF/ID to a NOP (takes precedence over ifid_stall)
//   idex_bubble      load a NOP control word into ID/EX
//   sys_req          registered; high while waiting for the handler
//   busy             the sequencer is not in RUN
//   stall_cnt        number of cycles with pc_stall=1, saturating
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_sys,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_br_taken,
    input  logic             sys_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             sys_req,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SYS    = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    localparam int               DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             sys_req_q, sys_req_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    // Register zero is hard-wired, so a load that targets it never creates a hazard.
    assign load_use = ex_memRead && (ex_rt != {REG_W{1'b0}}) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next-state and stall/flush/bubble decode.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        sys_req_d   = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            state_d     = ST_RUN;
            drain_cnt_d = {DW{1'b0}};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_br_taken) begin
                        // A taken branch kills the ID instruction, including a syscall there.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_sys) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end else if (id_jump) begin
                        ifid_flush  = 1'b1;
                    end else begin
                        ifid_flush  = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // EX holds only bubbles here, so branch and ack inputs are ignored.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    if (drain_cnt_q == {DW{1'b0}}) begin
                        state_d   = ST_SYS;
                        sys_req_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                    end
                end
                ST_SYS: begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                    if (sys_ack) begin
                        state_d   = ST_RESUME;
                        sys_req_d = 1'b0;
                    end else begin
                        sys_req_d = 1'b1;
                    end
                end
                ST_RESUME: begin
                    // Fetch restarts; the syscall itself retires as a NOP.
                    idex_bubble = 1'b1;
                    state_d     = ST_RUN;
                end
                default: begin
                    state_d     = ST_RUN;
                    drain_cnt_d = {DW{1'b0}};
                end
            endcase
        end
    end

    // Saturating stall-cycle counter update.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, drain counter, handler request and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= {DW{1'b0}};
            sys_req_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            sys_req_q   <= sys_req_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sys_req   = sys_req_q;
    assign busy      = !reset && (state_q != ST_RUN);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle RUN-state
// vectors followed by hand-written syscall, reset-abort and saturation sequences.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, id_jump, id_sys, ex_memRead, ex_br_taken, sys_ack;
    logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, sys_req, busy;
    logic [CNT_W-1:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_sys(id_sys),
        .ex_memRead(ex_memRead), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken),
        .sys_ack(sys_ack),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .sys_req(sys_req), .busy(busy),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs plus expected {pc_stall, ifid_stall, ifid_flush, idex_bubble}.
    typedef struct packed {
        logic             mr;
        logic [REG_W-1:0] ert;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             urt;
        logic             jmp;
        logic             sys;
        logic             br;
        logic [3:0]       exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_jump = 1'b0; id_sys = 1'b0;
        ex_memRead = 1'b0; ex_br_taken = 1'b0; sys_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [5:0] outs6();
        return {pc_stall, ifid_stall, ifid_flush, idex_bubble, busy, sys_req};
    endfunction

    initial begin
        logic [5:0] exp6;
        int         exp_stalls;

        //                mr    ert    rs     rt    urt   jmp   sys   br    exp
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1101};
        vecs[2]  = '{1'b0, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[3]  = '{1'b1, 5'd9,  5'd1,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{1'b1, 5'd9,  5'd1,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 4'b1101};
        vecs[5]  = '{1'b1, 5'd0,  5'd0,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[6]  = '{1'b1, 5'd0,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 4'b0011};
        vecs[8]  = '{1'b0, 5'd0,  5'd4,  5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 4'b0011};
        vecs[9]  = '{1'b0, 5'd0,  5'd4,  5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 4'b0010};
        vecs[10] = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'b1101};
        vecs[11] = '{1'b1, 5'd31, 5'd30, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[12] = '{1'b1, 5'd31, 5'd31, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 4'b1101};

        // Reset: outputs held low even with a live hazard on the inputs.
        reset = 1'b1;
        clear_inputs();
        ex_memRead = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        check("reset_comb_outs", {28'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble}, 32'd0);
        @(negedge clk);
        check("reset_sys_req", {31'd0, sys_req}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        reset = 1'b0;
        clear_inputs();

        // Table of RUN-state vectors, one per cycle.
        exp_stalls = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ex_memRead = vecs[i].mr; ex_rt = vecs[i].ert;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].urt;
            id_jump = vecs[i].jmp; id_sys = vecs[i].sys; ex_br_taken = vecs[i].br;
            #1;
            check($sformatf("vec%0d_outs", i),
                  {28'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble}, {28'd0, vecs[i].exp});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            if (vecs[i].exp[3]) exp_stalls++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check("table_stall_cnt", {28'd0, stall_cnt}, 32'(exp_stalls));
        check("table_busy_after", {31'd0, busy}, 32'd0);

        // Syscall sequence: stray branch and ack during DRAIN must be ignored.
        do_reset();
        @(negedge clk);
        id_sys = 1'b1;
        #1;
        check("sys_c0", {26'd0, outs6()}, {26'd0, 6'b110100});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            id_sys      = 1'b0;
            ex_br_taken = (c == 2);
            sys_ack     = (c == 2) || (c == 6);
            #1;
            if (c <= 3)      exp6 = 6'b110110;
            else if (c <= 6) exp6 = 6'b110111;
            else if (c == 7) exp6 = 6'b000110;
            else             exp6 = 6'b000000;
            check($sformatf("sys_c%0d", c), {26'd0, outs6()}, {26'd0, exp6});
        end
        check("sys_stall_cnt", {28'd0, stall_cnt}, 32'd7);

        // Reset while waiting for the handler aborts the sequence.
        do_reset();
        @(negedge clk);
        id_sys = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            id_sys = 1'b0;
        end
        #1;
        check("abort_sys_req_before", {31'd0, sys_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outs_in_reset", {28'd0, pc_stall, ifid_stall, ifid_flush, idex_bubble}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        sys_ack = 1'b1;
        #1;
        check("abort_sys_req", {31'd0, sys_req}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        #1;
        check("stray_ack_outs", {26'd0, outs6()}, 32'd0);
        check("stray_ack_cnt", {28'd0, stall_cnt}, 32'd0);
        sys_ack = 1'b0;

        // Saturation of the 4-bit counter under a held load-use hazard.
        do_reset();
        @(negedge clk);
        ex_memRead = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 10) check("sat_cnt_10", {28'd0, stall_cnt}, 32'd10);
        end
        #1;
        check("sat_cnt_final", {28'd0, stall_cnt}, 32'd15);
        check("sat_still_stall", {31'd0, pc_stall}, 32'd1);
        clear_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
